// File: rtl/instr_encoder.sv
// RV32I instruction encoder: decoded fields in, 32-bit words plus sequential imem word address out.
// Optional immediate range checking is enabled by defining IMM_RANGE_CHECK_EN.
//   state | meaning
//   IDLE  | no pending output
//   HOLD  | out_valid=1, word waiting for out_ready
//   FULL  | DEPTH words issued and drained; only clear restarts
module instr_encoder #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    kind,
  input  logic [2:0]    funct3,
  input  logic          funct7b5,
  input  logic [4:0]    rd,
  input  logic [4:0]    rs1,
  input  logic [4:0]    rs2,
  input  logic [20:0]   imm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_instr,
  output logic [AW-1:0] out_addr,
  output logic          full,
  output logic          err
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, HOLD, FULL} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            out_valid_q, full_q, err_q;
  logic [31:0]     instr_q, enc_d;
  logic [AW-1:0]   addr_q;
  logic            legal_d, accept, handshake;

  always_comb begin
    enc_d   = 32'h0;
    legal_d = 1'b1;
    case (kind)
      3'd0: enc_d = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
      3'd1: enc_d = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      3'd2: enc_d = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, 7'b0110011};
      3'd3: enc_d = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
      3'd4: enc_d = {imm[11:0], rs1, funct3, rd, 7'b0010011};
      3'd5: enc_d = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      default: legal_d = 1'b0;
    endcase
`ifdef IMM_RANGE_CHECK_EN
    // In range when the upper bits are a pure sign extension of the encodable field.
    case (kind)
      3'd0, 3'd1, 3'd4: if (imm[20:11] != {10{imm[11]}}) legal_d = 1'b0;
      3'd3: if ((imm[20:12] != {9{imm[12]}}) || imm[0]) legal_d = 1'b0;
      3'd5: if (imm[0]) legal_d = 1'b0;
      default: ;
    endcase
`endif
  end

  assign in_ready  = !clear && !full_q && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid_q && out_ready;
  assign cnt_d     = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      instr_q     <= 32'h0;
      addr_q      <= '0;
      full_q      <= 1'b0;
      err_q       <= 1'b0;
    end else if (clear) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      full_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          if (accept && legal_d) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
            instr_q     <= enc_d;
            addr_q      <= AW'(cnt_q);
            cnt_q       <= cnt_d;
            full_q      <= (cnt_d == CW'(DEPTH));
          end else begin
            if (accept) err_q <= 1'b1;
            if (handshake) begin
              out_valid_q <= 1'b0;
              state_q     <= full_q ? FULL : IDLE;
            end
          end
        end
        default: state_q <= FULL;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = instr_q;
  assign out_addr  = addr_q;
  assign full      = full_q;
  assign err       = err_q;

endmodule
